// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
// No logic here; only the FSM state encoding and parameter defaults.
// Imported by tdm_demux and its testbench.
package tdm_pkg;

  // FSM states: IDLE waits for a start-of-frame, RUN is mid-frame
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

endpackage

// File: rtl/tdm_slot_reg.sv
// Per-channel W-bit sample register with load enable.
// Latency: q updates on the rising edge where ld is high.
// Backpressure: none; the load is always accepted.
module tdm_slot_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the sample on load, otherwise hold the previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: spreads a framed sample stream over N_CH registered slots.
// Latency: 1 cycle from accepted sample to Y slot / YV / FV (and ERR).
// Backpressure: none; VLD=0 simply holds state. ERR exists only with TDM_DEMUX_ERR_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [W-1:0]              D,
  input  logic                      VLD,
  input  logic                      SOF,
  output logic [N_CH*W-1:0]         Y,
  output logic [N_CH-1:0]           YV,
  output logic                      FV,
  output logic [$clog2(N_CH)-1:0]   CH
`ifdef TDM_DEMUX_ERR_EN
  ,
  output logic                      ERR
`endif
);

  localparam int CW = $clog2(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   ch_nx;
  logic [N_CH-1:0] wr_en;
  logic            fv_nx;
`ifdef TDM_DEMUX_ERR_EN
  logic            err_nx;
`endif

  // State, channel counter and strobe registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      CH    <= '0;
      YV    <= '0;
      FV    <= 1'b0;
    end else begin
      state <= state_nx;
      CH    <= ch_nx;
      YV    <= wr_en;
      FV    <= fv_nx;
    end
  end

`ifdef TDM_DEMUX_ERR_EN
  // Error strobe register, aligned with where YV would have fired
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else begin
      ERR <= err_nx;
    end
  end
`endif

  // Next-state, slot write enables and frame/error strobes
  always_comb begin
    state_nx = state;
    ch_nx    = CH;
    wr_en    = '0;
    fv_nx    = 1'b0;
`ifdef TDM_DEMUX_ERR_EN
    err_nx   = 1'b0;
`endif
    if (VLD) begin
      if (SOF) begin
        // SOF always (re)starts a frame; in RUN it abandons the partial one
        wr_en[0] = 1'b1;
        ch_nx    = CW'(1);
        state_nx = RUN;
`ifdef TDM_DEMUX_ERR_EN
        err_nx   = (state == RUN);
`endif
      end else if (state == RUN) begin
        wr_en[CH] = 1'b1;
        if (CH == LAST_CH) begin
          ch_nx    = '0;
          state_nx = IDLE;
          fv_nx    = 1'b1;
        end else begin
          ch_nx = CH + CW'(1);
        end
      end else begin
        // Non-SOF sample with no frame in progress is dropped
`ifdef TDM_DEMUX_ERR_EN
        err_nx = 1'b1;
`endif
      end
    end
  end

  // One register per output slot, loaded by its write enable
  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    tdm_slot_reg #(.W(W)) u_slot (
      .clk (CLK),
      .rst (RST),
      .ld  (wr_en[k]),
      .d   (D),
      .q   (Y[k*W +: W])
    );
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux (N_CH=4, W=8).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// ERR checks are compiled in only when TDM_DEMUX_ERR_EN is defined.
module tb_tdm_demux;
  import tdm_pkg::*;

  logic        CLK;
  logic        RST;
  logic [7:0]  D;
  logic        VLD;
  logic        SOF;
  logic [31:0] Y;
  logic [3:0]  YV;
  logic        FV;
  logic [1:0]  CH;
`ifdef TDM_DEMUX_ERR_EN
  logic        ERR;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fv_seen = 0;
  int err_seen = 0;
  int fv_cyc1 = 0;
  int fv_cyc2 = 0;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .VLD (VLD),
    .SOF (SOF),
    .Y   (Y),
    .YV  (YV),
    .FV  (FV),
    .CH  (CH)
`ifdef TDM_DEMUX_ERR_EN
    ,
    .ERR (ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of input, then sample outputs just after the edge
  task automatic step(input logic [7:0] d, input logic v, input logic s);
    D = d; VLD = v; SOF = s;
    @(posedge CLK);
    #1;
    cyc++;
    VLD = 1'b0; SOF = 1'b0;
    if (FV) fv_seen++;
`ifdef TDM_DEMUX_ERR_EN
    if (ERR) err_seen++;
`endif
    check_eq("yv_onehot", 64'($countones(YV) <= 1), 64'd1);
  endtask

  task automatic outs(input string tag, input logic [3:0] yv, input logic fv, input logic [1:0] ch);
    check_eq({tag, "_yv"}, 64'(YV), 64'(yv));
    check_eq({tag, "_fv"}, 64'(FV), 64'(fv));
    check_eq({tag, "_ch"}, 64'(CH), 64'(ch));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    RST = 1'b0;
    #2;
  endtask

  initial begin
    RST = 1'b1; D = '0; VLD = 1'b0; SOF = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    // Reset state
    check_eq("rst_y", 64'(Y), 64'h0);
    outs("rst", 4'b0000, 1'b0, 2'd0);
`ifdef TDM_DEMUX_ERR_EN
    check_eq("rst_err", 64'(ERR), 64'd0);
`endif
    #3 RST = 1'b0;
    #2;

    // No SOF after reset: sample dropped
    step(8'h55, 1'b1, 1'b0);
    check_eq("nosof_y", 64'(Y), 64'h0);
    outs("nosof", 4'b0000, 1'b0, 2'd0);
`ifdef TDM_DEMUX_ERR_EN
    check_eq("nosof_err", 64'(ERR), 64'd1);
`endif
    step(8'h00, 1'b0, 1'b0);
`ifdef TDM_DEMUX_ERR_EN
    check_eq("nosof_err_clr", 64'(ERR), 64'd0);
`endif

    // Clean frame
    fv_seen = 0;
    step(8'h11, 1'b1, 1'b1); outs("clean0", 4'b0001, 1'b0, 2'd1);
    step(8'h22, 1'b1, 1'b0); outs("clean1", 4'b0010, 1'b0, 2'd2);
    step(8'h33, 1'b1, 1'b0); outs("clean2", 4'b0100, 1'b0, 2'd3);
    step(8'h44, 1'b1, 1'b0); outs("clean3", 4'b1000, 1'b1, 2'd0);
    check_eq("clean_y", 64'(Y), 64'h44332211);
    step(8'h00, 1'b0, 1'b0); outs("clean_idle", 4'b0000, 1'b0, 2'd0);
    check_eq("clean_fv_cnt", 64'(fv_seen), 64'd1);

    // Gapped frame (reset first so Y must be rebuilt)
    do_reset();
    check_eq("gap_pre_y", 64'(Y), 64'h0);
    fv_seen = 0;
    step(8'h11, 1'b1, 1'b1); outs("gap0", 4'b0001, 1'b0, 2'd1);
    step(8'h00, 1'b0, 1'b1); step(8'h00, 1'b0, 1'b0); outs("gap0h", 4'b0000, 1'b0, 2'd1);
    step(8'h22, 1'b1, 1'b0); outs("gap1", 4'b0010, 1'b0, 2'd2);
    step(8'h00, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0); outs("gap1h", 4'b0000, 1'b0, 2'd2);
    step(8'h33, 1'b1, 1'b0); outs("gap2", 4'b0100, 1'b0, 2'd3);
    step(8'h00, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0); outs("gap2h", 4'b0000, 1'b0, 2'd3);
    step(8'h44, 1'b1, 1'b0); outs("gap3", 4'b1000, 1'b1, 2'd0);
    check_eq("gap_y", 64'(Y), 64'h44332211);
    step(8'h00, 1'b0, 1'b0);
    check_eq("gap_fv_cnt", 64'(fv_seen), 64'd1);

    // Resync mid-frame
    fv_seen = 0; err_seen = 0;
    step(8'hA0, 1'b1, 1'b1); outs("rs_a0", 4'b0001, 1'b0, 2'd1);
    step(8'hA1, 1'b1, 1'b0); outs("rs_a1", 4'b0010, 1'b0, 2'd2);
    step(8'hB0, 1'b1, 1'b1); outs("rs_b0", 4'b0001, 1'b0, 2'd1);
`ifdef TDM_DEMUX_ERR_EN
    check_eq("rs_b0_err", 64'(ERR), 64'd1);
`endif
    step(8'hB1, 1'b1, 1'b0); outs("rs_b1", 4'b0010, 1'b0, 2'd2);
    check_eq("rs_partial_y", 64'(Y), 64'h4433B1B0);
    step(8'hB2, 1'b1, 1'b0); outs("rs_b2", 4'b0100, 1'b0, 2'd3);
    step(8'hB3, 1'b1, 1'b0); outs("rs_b3", 4'b1000, 1'b1, 2'd0);
    check_eq("rs_y", 64'(Y), 64'hB3B2B1B0);
    check_eq("rs_fv_cnt", 64'(fv_seen), 64'd1);
`ifdef TDM_DEMUX_ERR_EN
    check_eq("rs_err_cnt", 64'(err_seen), 64'd1);
`endif

    // Reset mid-frame takes effect without a clock edge
    step(8'hC0, 1'b1, 1'b1);
    step(8'hC1, 1'b1, 1'b0);
    check_eq("rm_pre_y", 64'(Y), 64'hB3B2C1C0);
    RST = 1'b1;
    #2;
    check_eq("rm_y", 64'(Y), 64'h0);
    outs("rm", 4'b0000, 1'b0, 2'd0);
    #2 RST = 1'b0;
    step(8'hC2, 1'b1, 1'b0);
    check_eq("rm_drop_y", 64'(Y), 64'h0);
    outs("rm_drop", 4'b0000, 1'b0, 2'd0);
`ifdef TDM_DEMUX_ERR_EN
    check_eq("rm_drop_err", 64'(ERR), 64'd1);
`endif

    // Back-to-back frames
    fv_seen = 0;
    step(8'h01, 1'b1, 1'b1); outs("bb0", 4'b0001, 1'b0, 2'd1);
    check_eq("bb0_y", 64'(Y), 64'h00000001);
    step(8'h02, 1'b1, 1'b0);
    step(8'h03, 1'b1, 1'b0);
    step(8'h04, 1'b1, 1'b0); outs("bb3", 4'b1000, 1'b1, 2'd0);
    fv_cyc1 = cyc;
    check_eq("bb_f1_y", 64'(Y), 64'h04030201);
    step(8'h05, 1'b1, 1'b1); outs("bb4", 4'b0001, 1'b0, 2'd1);
    check_eq("bb4_y", 64'(Y), 64'h04030205);
    step(8'h06, 1'b1, 1'b0); outs("bb5", 4'b0010, 1'b0, 2'd2);
    step(8'h07, 1'b1, 1'b0); outs("bb6", 4'b0100, 1'b0, 2'd3);
    step(8'h08, 1'b1, 1'b0); outs("bb7", 4'b1000, 1'b1, 2'd0);
    fv_cyc2 = cyc;
    check_eq("bb_f2_y", 64'(Y), 64'h08070605);
    check_eq("bb_fv_gap", 64'(fv_cyc2 - fv_cyc1), 64'd4);
    check_eq("bb_fv_cnt", 64'(fv_seen), 64'd2);
    step(8'h00, 1'b0, 1'b0); outs("bb_idle", 4'b0000, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of output channels (2..16).
REQ-002 The block SHALL have parameter W, default 8, giving the sample width in bits.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port D, input, W bits: the time-multiplexed sample stream.
REQ-006 The block SHALL have port VLD, input, 1 bit: D holds a valid sample this cycle.
REQ-007 The block SHALL have port SOF, input, 1 bit: start of frame, qualified by VLD; marks the channel-0 sample.
REQ-008 The block SHALL have port Y, output, N_CH*W bits: registered channel outputs, with channel k at bits [k*W +: W].
REQ-009 The block SHALL have port YV, output, N_CH bits: per-channel update strobe, one cycle wide.
REQ-010 The block SHALL have port FV, output, 1 bit: frame-complete strobe, one cycle wide.
REQ-011 The block SHALL have port CH, output, clog2(N_CH) bits: index of the channel the next non-SOF sample is written to.
REQ-012 The block SHALL have port ERR, output, 1 bit: framing-error strobe; it SHALL be present only under TDM_DEMUX_ERR_EN.

Function
REQ-013 The FSM SHALL have two states: IDLE (waiting for SOF) and RUN (mid-frame).
REQ-014 On VLD=1 and SOF=1, in either state, D SHALL be written to channel 0, CH SHALL become 1 and the state SHALL become RUN.
REQ-015 In RUN on VLD=1 and SOF=0, D SHALL be written to channel CH and CH SHALL increment.
REQ-016 When channel N_CH-1 is written, CH SHALL wrap to 0 and the state SHALL return to IDLE.
REQ-017 In IDLE, VLD=1 with SOF=0 SHALL drop the sample: no Y change, no YV strobe.
REQ-018 VLD=0 SHALL hold all state; SOF is ignored when VLD=0.
REQ-019 Latency SHALL be 1 cycle: a sample accepted at edge t appears on its Y slot after edge t, with YV[k]=1 for exactly that cycle.
REQ-020 Untouched Y slots SHALL hold their previous values.
REQ-021 FV SHALL pulse in the same cycle as YV[N_CH-1] when a frame completes.
REQ-022 SOF arriving in RUN with CH!=0 SHALL resynchronise: the partial frame is abandoned, already-written slots keep their values, and no FV is issued for the abandoned frame.
REQ-023 At most one YV bit SHALL be high in any cycle.

Reset
REQ-024 While RST=1: state=IDLE, CH=0, Y=0, YV=0, FV=0 and ERR=0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; the first sample accepted after release must carry SOF.
REQ-026 Release of reset SHALL take effect at the first rising edge of CLK after RST falls.

Configuration
REQ-027 With macro TDM_DEMUX_ERR_EN defined, ERR SHALL pulse one cycle, aligned with where the YV strobe would be, on:
- a dropped sample (REQ-017);
- a resync (REQ-022).
REQ-028 Without TDM_DEMUX_ERR_EN, the ERR port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package tdm_pkg SHALL hold:
- the FSM state enum (IDLE, RUN);
- default constants for N_CH and W.
REQ-030 Per-channel storage SHALL be sub-module tdm_slot_reg (W-bit register with load enable and async reset), instantiated N_CH times; the FSM and counter SHALL stay in tdm_demux.

Verification
REQ-031 Clean frame: N_CH=4, W=8; samples 0x11(SOF), 0x22, 0x33, 0x44 on consecutive cycles -> Y=0x44332211; YV=0001,0010,0100,1000 one cycle after each sample; FV with the last YV.
REQ-032 Gapped frame: the same samples with VLD=0 gaps of 2 cycles -> same Y; each YV one cycle after its sample; FV once; CH holds across gaps.
REQ-033 No SOF after reset: 0x55 with VLD=1, SOF=0 -> Y stays 0, no YV; ERR=1 one cycle later with TDM_DEMUX_ERR_EN.
REQ-034 Resync: 0xA0(SOF), 0xA1, then 0xB0(SOF), 0xB1, 0xB2, 0xB3 -> no FV after 0xA1; final Y=0xB3B2B1B0; single FV; ERR pulses once at 0xB0 with TDM_DEMUX_ERR_EN.
REQ-035 Reset mid-frame: RST after 2 of 4 samples -> Y=0, CH=0, IDLE immediately (asynchronous); next non-SOF sample is dropped.
REQ-036 Back-to-back frames: two 4-sample frames with no gap, each starting with SOF -> two FV pulses 4 cycles apart, Y updated per slot.
